rate_mult_decoder: RTL and testbench

Measures the pulse density of the Z stream produced by the s420-style binary rate multiplier and recovers the multiplier code that generated it. It counts enabled cycles (P_0 high) over a fixed window and counts how many of those cycles had Z high. The count it reports is the recovered code. It sits at the receiving end of the rate-multiplier link, in the same clock domain as the generator, and is used for self-check and for loopback calibration.

---
 rtl/rate_mult_pkg.sv | 18 +
 rtl/rate_mult_decoder_if.sv | 24 ++
 rtl/rate_dec_sync.sv | 20 ++
 rtl/rate_mult_decoder.sv | 111 +++++++++++
 tb/tb_rate_mult_decoder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rate_mult_pkg.sv
// Shared types and helpers for the rate-multiplier decoder.
// Holds the FSM state enum, the default window size and the window-length helper.
package rate_mult_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeasure,
        StDone
    } dec_state_e;

    localparam int unsigned WindowLog2Default = 16;

    function automatic int unsigned window_len(input int unsigned log2);
        return 32'd1 << log2;
    endfunction

endpackage

// File: rtl/rate_mult_decoder_if.sv
// Measurement link between a controller (master) and rate_mult_decoder (slave).
// Carries the sampled stream, the start/abort controls and the measurement results.
interface rate_mult_decoder_if #(
    parameter int unsigned WINDOW_LOG2 = 16
);
    logic                   P_0;
    logic                   Z;
    logic                   START;
    logic                   ABORT;
    logic                   BUSY;
    logic                   VALID;
    logic [WINDOW_LOG2:0]   C_EST;
    logic                   OVF;

    modport master (
        output P_0, Z, START, ABORT,
        input  BUSY, VALID, C_EST, OVF
    );

    modport slave (
        input  P_0, Z, START, ABORT,
        output BUSY, VALID, C_EST, OVF
    );
endinterface

// File: rtl/rate_dec_sync.sv
// Two-flop synchronizer, reset to 0, for a single-bit level signal.
// Used by rate_mult_decoder only when RATE_DEC_SYNC_EN is defined.
module rate_dec_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/rate_mult_decoder.sv
// Recovers a rate-multiplier code by counting Z-high enabled cycles over 2^WINDOW_LOG2 enables.
// Optional RATE_DEC_SYNC_EN: pass P_0 and Z through two-flop synchronizers first.
module rate_mult_decoder
    import rate_mult_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = WindowLog2Default
) (
    input logic                CK,
    input logic                RN,
    rate_mult_decoder_if.slave bus
);
    localparam logic [WINDOW_LOG2-1:0] LastCnt = WINDOW_LOG2'(window_len(WINDOW_LOG2) - 1);

    logic p0;
    logic z;

`ifdef RATE_DEC_SYNC_EN
    rate_dec_sync u_sync_p0 (
        .clk   (CK),
        .rst_n (RN),
        .d     (bus.P_0),
        .q     (p0)
    );

    rate_dec_sync u_sync_z (
        .clk   (CK),
        .rst_n (RN),
        .d     (bus.Z),
        .q     (z)
    );
`else
    assign p0 = bus.P_0;
    assign z  = bus.Z;
`endif

    dec_state_e             state;
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [WINDOW_LOG2:0]   acc;
    logic [WINDOW_LOG2:0]   acc_inc;
    logic                   busy;
    logic                   valid;
    logic [WINDOW_LOG2:0]   c_est;
    logic                   ovf;
    logic                   take_start;

    assign acc_inc    = acc + {{WINDOW_LOG2{1'b0}}, z};
    assign take_start = bus.START && (state == StIdle || state == StDone);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state   <= StIdle;
            win_cnt <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            c_est   <= '0;
            ovf     <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                StIdle: state <= StIdle;
                StArm: begin
                    if (bus.ABORT) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (p0) begin
                        // The enable that ends ARM is the first sample of the window.
                        state   <= StMeasure;
                        win_cnt <= win_cnt + 1'b1;
                        acc     <= acc_inc;
                    end
                end
                StMeasure: begin
                    if (bus.ABORT) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (p0) begin
                        win_cnt <= win_cnt + 1'b1;
                        acc     <= acc_inc;
                        if (win_cnt == LastCnt) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            valid <= 1'b1;
                            c_est <= acc_inc;
                        end
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase

            if (bus.START && (state == StArm || state == StMeasure)) begin
                ovf <= 1'b1;
            end

            // Accepted START overrides the IDLE/DONE transitions above.
            if (take_start) begin
                state   <= StArm;
                win_cnt <= '0;
                acc     <= '0;
                busy    <= 1'b1;
                ovf     <= 1'b0;
            end
        end
    end

    assign bus.BUSY  = busy;
    assign bus.VALID = valid;
    assign bus.C_EST = c_est;
    assign bus.OVF   = ovf;
endmodule

// File: tb/tb_rate_mult_decoder.sv
// Directed self-checking bench for rate_mult_decoder at WINDOW_LOG2=4 (default build).
// Table-driven windows plus hand-written abort, overflow and mid-window reset sequences.
module tb_rate_mult_decoder;
    localparam int unsigned W = 4;

    logic CK;
    logic RN;
    int   checks;
    int   errors;

    rate_mult_decoder_if #(.WINDOW_LOG2(W)) bus ();

    rate_mult_decoder #(.WINDOW_LOG2(W)) dut (
        .CK  (CK),
        .RN  (RN),
        .bus (bus)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct {
        int unsigned period;
        logic [15:0] mask;
        logic        z_idle;
        logic [4:0]  exp;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One full window: enables every `period` cycles, Z from mask on enables, z_idle otherwise.
    task automatic run_window(input int unsigned period, input logic [15:0] mask,
                              input logic z_idle, input logic [4:0] exp, input string tag);
        int unsigned en;
        int unsigned k;
        int          early;
        logic        p0;
        en    = 0;
        k     = 0;
        early = 0;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        check({tag, " busy after start"}, 32'(bus.BUSY), 32'd1);
        while (en < 16 && k < 200) begin
            p0 = ((k % period) == 0);
            bus.P_0 = p0;
            bus.Z   = p0 ? mask[en] : z_idle;
            tick();
            if (p0) en++;
            k++;
            if (en < 16 && bus.VALID) early++;
        end
        check({tag, " no early valid"}, 32'(early), 32'd0);
        check({tag, " valid"}, 32'(bus.VALID), 32'd1);
        check({tag, " busy low in done"}, 32'(bus.BUSY), 32'd0);
        check({tag, " c_est"}, 32'(bus.C_EST), 32'(exp));
        check({tag, " ovf"}, 32'(bus.OVF), 32'd0);
        bus.P_0 = 1'b0;
        bus.Z   = 1'b0;
        tick();
        check({tag, " valid one cycle"}, 32'(bus.VALID), 32'd0);
    endtask

    initial begin
        int nvalid;
        int nbusy;
        logic [4:0] last_exp;
        checks = 0;
        errors = 0;
        RN        = 1'b0;
        bus.P_0   = 1'b0;
        bus.Z     = 1'b0;
        bus.START = 1'b0;
        bus.ABORT = 1'b0;

        vecs[0] = '{1, 16'hFFFF, 1'b0, 5'd16};
        vecs[1] = '{2, 16'h1111, 1'b1, 5'd4};
        vecs[2] = '{3, 16'h0000, 1'b1, 5'd0};
        vecs[3] = '{1, 16'hAAAA, 1'b0, 5'd8};
        vecs[4] = '{2, 16'h8001, 1'b1, 5'd2};
        vecs[5] = '{3, 16'h7FFF, 1'b0, 5'd15};

        #12;
        check("reset busy", 32'(bus.BUSY), 32'd0);
        check("reset valid", 32'(bus.VALID), 32'd0);
        check("reset c_est", 32'(bus.C_EST), 32'd0);
        check("reset ovf", 32'(bus.OVF), 32'd0);
        RN = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_window(vecs[i].period, vecs[i].mask, vecs[i].z_idle, vecs[i].exp,
                       $sformatf("vec%0d", i));
        end
        last_exp = vecs[5].exp;

        // Abort on enabled cycle 7: no VALID, C_EST retained, next window still works.
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.P_0 = 1'b1;
            bus.Z   = 1'b1;
            tick();
        end
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        check("abort busy", 32'(bus.BUSY), 32'd0);
        nvalid = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.VALID) nvalid++;
        end
        check("abort no valid", 32'(nvalid), 32'd0);
        check("abort c_est kept", 32'(bus.C_EST), 32'(last_exp));
        run_window(1, 16'h0000, 1'b0, 5'd0, "after abort");

        // START while busy sets OVF; START in DONE is accepted and clears it.
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus.P_0   = 1'b1;
            bus.Z     = 1'b1;
            bus.START = (k == 3);
            tick();
            if (k == 3) check("ovf set", 32'(bus.OVF), 32'd1);
        end
        bus.START = 1'b0;
        check("ovf window valid", 32'(bus.VALID), 32'd1);
        check("ovf window c_est", 32'(bus.C_EST), 32'd16);
        check("ovf sticky", 32'(bus.OVF), 32'd1);
        bus.P_0   = 1'b0;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        check("b2b busy", 32'(bus.BUSY), 32'd1);
        check("b2b ovf cleared", 32'(bus.OVF), 32'd0);
        check("b2b valid low", 32'(bus.VALID), 32'd0);
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        check("b2b abort", 32'(bus.BUSY), 32'd0);

        // START beats ABORT in IDLE, then asynchronous reset mid-window.
        bus.START = 1'b1;
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        bus.START = 1'b0;
        check("start wins abort", 32'(bus.BUSY), 32'd1);
        for (int k = 0; k < 5; k++) begin
            bus.P_0   = 1'b1;
            bus.Z     = 1'b1;
            bus.START = (k == 2);
            tick();
        end
        bus.START = 1'b0;
        check("pre-reset ovf", 32'(bus.OVF), 32'd1);
        #3;
        RN = 1'b0;
        #1;
        check("async rst busy", 32'(bus.BUSY), 32'd0);
        check("async rst valid", 32'(bus.VALID), 32'd0);
        check("async rst c_est", 32'(bus.C_EST), 32'd0);
        check("async rst ovf", 32'(bus.OVF), 32'd0);
        #10;
        RN = 1'b1;
        nvalid = 0;
        nbusy  = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (bus.VALID) nvalid++;
            if (bus.BUSY) nbusy++;
        end
        check("post-reset no valid", 32'(nvalid), 32'd0);
        check("post-reset idle", 32'(nbusy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
